// File: rtl/ae_key_ctrl.sv
// ae_key_ctrl: exposure adjust from two debounced keys, with hold-to-repeat and a
// request/ack handshake that pushes each new exposure code to a sensor register writer.
//
// Ports:
//   I_sysclk   - single clock for all logic
//   I_rst      - synchronous active-high reset
//   I_inc_down - one-cycle pulse, "increase" key pressed
//   I_inc_up   - one-cycle pulse, "increase" key released
//   I_dec_down - one-cycle pulse, "decrease" key pressed
//   I_dec_up   - one-cycle pulse, "decrease" key released
//   I_wr_ack   - writer accepted O_wr_data
//   O_exp      - current exposure code
//   O_wr_req   - write request, held until acknowledged
//   O_wr_data  - exposure code carried by the request
//   O_busy     - controller is not idle (registered)
module ae_key_ctrl #(
   parameter logic [63:0] REF_CLK   = 64'd50_000_000, // I_sysclk frequency in Hz
   parameter int unsigned LONG_MS   = 500,            // hold time before auto-repeat, ms
   parameter int unsigned REPEAT_MS = 100,            // auto-repeat period, ms
   parameter logic [15:0] EXP_MIN   = 16'd16,         // minimum exposure code
   parameter logic [15:0] EXP_MAX   = 16'd1000,       // maximum exposure code
   parameter logic [15:0] EXP_DEF   = 16'd200,        // exposure code after reset
   parameter logic [15:0] STEP      = 16'd8           // exposure increment per step
) (
   input  logic        I_sysclk,
   input  logic        I_rst,
   input  logic        I_inc_down,
   input  logic        I_inc_up,
   input  logic        I_dec_down,
   input  logic        I_dec_up,
   input  logic        I_wr_ack,
   output logic [15:0] O_exp,
   output logic        O_wr_req,
   output logic [15:0] O_wr_data,
   output logic        O_busy
);

   localparam logic [63:0] TICK_DIV  = REF_CLK / 64'd1000;
   localparam int unsigned TICK_W    = (TICK_DIV > 64'd1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 64'd1);
   localparam logic [15:0] LONG_LAST = 16'(LONG_MS - 1);
   localparam logic [15:0] RPT_LAST  = 16'(REPEAT_MS - 1);

   typedef enum logic [1:0] {K_IDLE, K_HOLD, K_RPT} key_state_e;
   typedef enum logic {W_IDLE, W_REQ} wr_state_e;

   key_state_e        key_q, key_d;
   wr_state_e         wr_q, wr_d;
   logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
   logic [15:0]       ms_q, ms_d;
   logic              sel_inc_q, sel_inc_d;
   logic [15:0]       exp_q, exp_d;
   logic [15:0]       wr_data_q, wr_data_d;
   logic              pend_q, pend_d;
   logic              busy_q, busy_d;

   logic        tick;
   logic        step;
   logic        sel_up;
   logic [16:0] inc_sum;
   logic [16:0] dec_floor;
   logic [15:0] inc_val;
   logic [15:0] dec_val;

   assign tick = (tick_cnt_q == TICK_LAST);

   // Saturating step values, evaluated at 17 bits so neither direction can wrap.
   assign inc_sum   = {1'b0, exp_q} + {1'b0, STEP};
   assign dec_floor = {1'b0, EXP_MIN} + {1'b0, STEP};
   assign inc_val   = (inc_sum > {1'b0, EXP_MAX}) ? EXP_MAX : inc_sum[15:0];
   assign dec_val   = ({1'b0, exp_q} < dec_floor) ? EXP_MIN : (exp_q - STEP);

   always_comb begin
      tick_cnt_d = tick ? '0 : (tick_cnt_q + 1'b1);
      key_d      = key_q;
      ms_d       = ms_q;
      sel_inc_d  = sel_inc_q;
      step       = 1'b0;
      sel_up     = sel_inc_q ? I_inc_up : I_dec_up;

      case (key_q)
         K_IDLE: begin
            // Simultaneous presses resolve to "increase".
            if (I_inc_down) begin
               sel_inc_d = 1'b1;
               step      = 1'b1;
               ms_d      = '0;
               key_d     = K_HOLD;
            end else if (I_dec_down) begin
               sel_inc_d = 1'b0;
               step      = 1'b1;
               ms_d      = '0;
               key_d     = K_HOLD;
            end
         end
         K_HOLD: begin
            // Release beats a coincident tick: no step on the release cycle.
            if (sel_up) begin
               key_d = K_IDLE;
            end else if (tick) begin
               if (ms_q == LONG_LAST) begin
                  step  = 1'b1;
                  ms_d  = '0;
                  key_d = K_RPT;
               end else begin
                  ms_d = ms_q + 16'd1;
               end
            end
         end
         K_RPT: begin
            if (sel_up) begin
               key_d = K_IDLE;
            end else if (tick) begin
               if (ms_q == RPT_LAST) begin
                  step = 1'b1;
                  ms_d = '0;
               end else begin
                  ms_d = ms_q + 16'd1;
               end
            end
         end
         default: key_d = K_IDLE;
      endcase

      exp_d = exp_q;
      if (step) begin
         exp_d = sel_inc_d ? inc_val : dec_val;
      end

      wr_d      = wr_q;
      wr_data_d = wr_data_q;
      pend_d    = pend_q;
      case (wr_q)
         W_IDLE: begin
            if (pend_q) begin
               wr_d      = W_REQ;
               wr_data_d = exp_q;
               pend_d    = 1'b0;
            end
         end
         W_REQ: begin
            if (I_wr_ack) begin
               wr_d = W_IDLE;
            end
         end
         default: wr_d = W_IDLE;
      endcase

      // A real change always leaves a write pending, even if a launch happens this cycle;
      // steps during W_REQ coalesce into one follow-up write.
      if (exp_d != exp_q) begin
         pend_d = 1'b1;
      end

      busy_d = (key_d != K_IDLE) | (wr_d != W_IDLE) | pend_d;
   end

   always_ff @(posedge I_sysclk) begin
      if (I_rst) begin
         key_q      <= K_IDLE;
         wr_q       <= W_IDLE;
         tick_cnt_q <= '0;
         ms_q       <= '0;
         sel_inc_q  <= 1'b0;
         exp_q      <= EXP_DEF;
         wr_data_q  <= '0;
         pend_q     <= 1'b1;
         busy_q     <= 1'b1;
      end else begin
         key_q      <= key_d;
         wr_q       <= wr_d;
         tick_cnt_q <= tick_cnt_d;
         ms_q       <= ms_d;
         sel_inc_q  <= sel_inc_d;
         exp_q      <= exp_d;
         wr_data_q  <= wr_data_d;
         pend_q     <= pend_d;
         busy_q     <= busy_d;
      end
   end

   assign O_exp     = exp_q;
   assign O_wr_req  = (wr_q == W_REQ);
   assign O_wr_data = wr_data_q;
   assign O_busy    = busy_q;

endmodule

// File: tb/tb_ae_key_ctrl.sv
// Bench for ae_key_ctrl: directed scenarios with literal expectations plus a long
// randomized run, all compared every cycle against a behavioural model.
module tb_ae_key_ctrl;

   localparam int TDIV = 4;   // 4000 Hz / 1000
   localparam int LONG = 5;
   localparam int REP  = 2;
   localparam int EMIN = 16;
   localparam int EMAX = 64;
   localparam int EDEF = 32;
   localparam int ESTP = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        inc_dn = 1'b0, inc_up = 1'b0, dec_dn = 1'b0, dec_up = 1'b0;
   logic        wr_ack = 1'b0;
   logic [15:0] o_exp, o_wr_data;
   logic        o_wr_req, o_busy;

   int checks = 0;
   int errors = 0;
   int ack_mode = 0;  // 0: never ack, 1: ack every request at once, 2: random
   int wr_cnt = 0;
   int last_wr = -1;

   // Model state
   bit m_valid = 1'b0;
   int m_exp, m_mode, m_ms, m_cyc, m_data;
   bit m_sel_inc, m_pend, m_req;

   ae_key_ctrl #(
      .REF_CLK  (64'd4000),
      .LONG_MS  (LONG),
      .REPEAT_MS(REP),
      .EXP_MIN  (16'(EMIN)),
      .EXP_MAX  (16'(EMAX)),
      .EXP_DEF  (16'(EDEF)),
      .STEP     (16'(ESTP))
   ) dut (
      .I_sysclk  (clk),
      .I_rst     (rst),
      .I_inc_down(inc_dn),
      .I_inc_up  (inc_up),
      .I_dec_down(dec_dn),
      .I_dec_up  (dec_up),
      .I_wr_ack  (wr_ack),
      .O_exp     (o_exp),
      .O_wr_req  (o_wr_req),
      .O_wr_data (o_wr_data),
      .O_busy    (o_busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
      end
   endtask

   // Behavioural model: mode 0 idle, 1 holding (waiting LONG ms), 2 repeating.
   always @(posedge clk) begin : model
      int e, md, ms, dat, lim;
      bit tk, stp, sinc, pend, rq, up;
      if (rst) begin
         m_valid <= 1'b1;
         m_exp <= EDEF; m_mode <= 0; m_ms <= 0; m_cyc <= 0; m_sel_inc <= 1'b0;
         m_pend <= 1'b1; m_req <= 1'b0; m_data <= 0;
      end else if (m_valid) begin
         tk = (m_cyc % TDIV) == (TDIV - 1);
         md = m_mode; ms = m_ms; sinc = m_sel_inc; stp = 1'b0;
         if (md == 0) begin
            if (inc_dn) begin sinc = 1'b1; stp = 1'b1; ms = 0; md = 1; end
            else if (dec_dn) begin sinc = 1'b0; stp = 1'b1; ms = 0; md = 1; end
         end else begin
            up  = sinc ? inc_up : dec_up;
            lim = (md == 1) ? LONG : REP;
            if (up) md = 0;
            else if (tk) begin
               if (ms == lim - 1) begin stp = 1'b1; ms = 0; md = 2; end
               else ms = ms + 1;
            end
         end
         e = m_exp;
         if (stp) begin
            if (sinc) e = (m_exp + ESTP > EMAX) ? EMAX : m_exp + ESTP;
            else      e = (m_exp - ESTP < EMIN) ? EMIN : m_exp - ESTP;
         end
         pend = m_pend; rq = m_req; dat = m_data;
         if (rq) begin
            if (wr_ack) rq = 1'b0;
         end else if (pend) begin
            rq = 1'b1; dat = m_exp; pend = 1'b0;
         end
         if (e != m_exp) pend = 1'b1;
         m_cyc <= m_cyc + 1; m_mode <= md; m_ms <= ms; m_sel_inc <= sinc;
         m_exp <= e; m_pend <= pend; m_req <= rq; m_data <= dat;
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (m_valid) begin
         chk("exp", int'(o_exp), m_exp);
         chk("wr_req", int'(o_wr_req), int'(m_req));
         chk("wr_data", int'(o_wr_data), m_data);
         chk("busy", int'(o_busy), int'((m_mode != 0) | m_req | m_pend));
      end
   end

   // Ack driver.
   always @(negedge clk) begin
      case (ack_mode)
         1:       wr_ack = o_wr_req;
         2:       wr_ack = ($urandom_range(0, 2) == 0);
         default: wr_ack = 1'b0;
      endcase
   end

   // Completed handshakes.
   always @(posedge clk) begin
      if (!rst && o_wr_req && wr_ack) begin
         wr_cnt  <= wr_cnt + 1;
         last_wr <= int'(o_wr_data);
      end
   end

   task automatic nxt(input int n = 1);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic pulse(input logic a, input logic b, input logic c, input logic d);
      {inc_dn, inc_up, dec_dn, dec_up} = {a, b, c, d};
      nxt();
      {inc_dn, inc_up, dec_dn, dec_up} = 4'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      nxt(2);
      rst = 1'b0;
   endtask

   task automatic reset_settle();
      ack_mode = 1;
      do_reset();
      nxt(6);
   endtask

   initial begin
      int w0;
      // Reset release issues the default write; ack three cycles later.
      ack_mode = 0;
      do_reset();
      nxt();
      chk("rst_req", int'(o_wr_req), 1);
      chk("rst_data", int'(o_wr_data), 32);
      chk("rst_exp", int'(o_exp), 32);
      nxt(2);
      ack_mode = 1;
      nxt(2);
      chk("ack_req_low", int'(o_wr_req), 0);
      chk("ack_busy_low", int'(o_busy), 0);

      // Short press: one step, one write, no repeat.
      w0 = wr_cnt;
      pulse(1, 0, 0, 0);
      chk("short_exp1", int'(o_exp), 40);
      nxt(8);
      pulse(0, 1, 0, 0);
      nxt(6);
      chk("short_exp", int'(o_exp), 40);
      chk("short_writes", wr_cnt - w0, 1);
      chk("short_data", last_wr, 40);

      // Long hold climbs to the ceiling, then writes stop.
      reset_settle();
      w0 = wr_cnt;
      pulse(1, 0, 0, 0);
      chk("hold_exp1", int'(o_exp), 40);
      nxt(60);
      chk("hold_exp_max", int'(o_exp), 64);
      chk("hold_writes", wr_cnt - w0, 4);
      chk("hold_last", last_wr, 64);
      w0 = wr_cnt;
      nxt(20);
      chk("hold_no_more", wr_cnt - w0, 0);
      pulse(0, 1, 0, 0);
      nxt(4);

      // Withheld ack while decreasing to the floor: writes coalesce.
      reset_settle();
      ack_mode = 0;
      pulse(0, 0, 1, 0);
      nxt(40);
      chk("coal_req", int'(o_wr_req), 1);
      chk("coal_data", int'(o_wr_data), 24);
      chk("coal_exp", int'(o_exp), 16);
      w0 = wr_cnt;
      pulse(0, 0, 0, 1);
      ack_mode = 1;
      nxt(8);
      chk("coal_writes", wr_cnt - w0, 2);
      chk("coal_last", last_wr, 16);

      // Simultaneous presses: increase wins, stray dec_up ignored during hold.
      reset_settle();
      pulse(1, 0, 1, 0);
      chk("both_exp", int'(o_exp), 40);
      nxt();
      pulse(0, 0, 0, 1);
      nxt(20);
      chk("both_hold_exp", int'(o_exp), 48);
      chk("both_busy", int'(o_busy), 1);
      pulse(0, 1, 0, 0);
      nxt(6);

      // Reset during an outstanding request.
      reset_settle();
      ack_mode = 0;
      pulse(1, 0, 0, 0);
      pulse(0, 1, 0, 0);
      pulse(1, 0, 0, 0);
      pulse(0, 1, 0, 0);
      chk("prerst_req", int'(o_wr_req), 1);
      chk("prerst_exp", int'(o_exp), 48);
      rst = 1'b1;
      nxt();
      chk("inrst_req", int'(o_wr_req), 0);
      chk("inrst_exp", int'(o_exp), 32);
      rst = 1'b0;
      nxt();
      chk("postrst_req", int'(o_wr_req), 1);
      chk("postrst_data", int'(o_wr_data), 32);

      // Randomized run.
      ack_mode = 2;
      for (int i = 0; i < 3000; i++) begin
         inc_dn = ($urandom_range(0, 15) == 0);
         dec_dn = ($urandom_range(0, 15) == 0);
         inc_up = ($urandom_range(0, 30) == 0);
         dec_up = ($urandom_range(0, 30) == 0);
         rst    = ($urandom_range(0, 599) == 0);
         nxt();
      end
      {inc_dn, inc_up, dec_dn, dec_up, rst} = 5'b0;
      nxt(4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
